// File: rtl/pio_pkg.sv
// ----------------------------------------------------------------------------
// pio_pkg
// Shared constants for the pio_edge_irq GPIO slave:
//   - word addresses of the bus-visible registers
//   - capture-condition codes for the per-bit edge detector
//   - edge_hit(): the capture condition for one bit, given its current and
//     previous filtered value
// ----------------------------------------------------------------------------
package pio_pkg;

    // Register map (word index on the 3-bit address bus).
    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_OUT  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAP  = 3'd3;
    localparam logic [2:0] ADDR_SET  = 3'd4;
    localparam logic [2:0] ADDR_CLR  = 3'd5;

    // Capture conditions.
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Any unrecognised code behaves as rising.
    function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
        case (edge_type)
            EDGE_FALLING: return ~cur & prev;
            EDGE_ANY:     return cur ^ prev;
            default:      return cur & ~prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_in_chan.sv
// ----------------------------------------------------------------------------
// pio_in_chan
// One input bit of the PIO: 2-FF synchroniser, optional debounce filter,
// filtered value f, its one-cycle delayed copy, and the edge pulse.
//
// Build option: PIO_DEBOUNCE_EN
//   defined   -> f follows s2 only after s2 has differed from f for
//                DEBOUNCE_CYCLES consecutive cycles.
//   undefined -> f <= s2 every cycle; no counter exists.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   in_bit    in   asynchronous input bit
//   filt      out  registered filtered value f
//   edge_det  out  one-cycle pulse when f/f_prev meet the EDGE_TYPE condition
// ----------------------------------------------------------------------------
module pio_in_chan
    import pio_pkg::*;
#(
    parameter int EDGE_TYPE       = EDGE_RISING,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic filt,
    output logic edge_det
);

    logic s1;
    logic s2;
    logic f;
    logic f_prev;

    // NOTE: every clocked process uses non-blocking assignments so that all
    // flops sample the pre-edge values; s2 <= s1 then really is a second stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            f_prev <= 1'b0;
        end else begin
            s1     <= in_bit;
            s2     <= s1;
            f_prev <= f;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // The counter measures how long s2 has disagreed with f; any agreement
    // restarts the window, so short glitches never reach f.
    always_ff @(posedge clk) begin
        if (reset) begin
            f   <= 1'b0;
            cnt <= '0;
        end else if (s2 == f) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            f   <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    // Without the filter the stability window has no meaning.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    always_ff @(posedge clk) begin
        if (reset) begin
            f <= 1'b0;
        end else begin
            f <= s2;
        end
    end
`endif

    assign filt     = f;
    assign edge_det = edge_hit(EDGE_TYPE, f, f_prev);

endmodule

// File: rtl/pio_edge_irq.sv
// ----------------------------------------------------------------------------
// pio_edge_irq
// WIDTH-bit GPIO slave for the Nios II system bus: synchronised (optionally
// debounced) inputs with per-bit edge capture, write-1-to-clear capture
// register, maskable level interrupt, and an output register with set/clear
// aliases.
//
// Build option: PIO_DEBOUNCE_EN (see pio_in_chan) enables the input filter.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   address     in   [2:0]  word register index
//   chipselect  in   slave select
//   write_n     in   active-low write strobe, qualified by chipselect
//   writedata   in   [31:0] write data (bits >= WIDTH ignored)
//   readdata    out  [31:0] registered read data, valid one cycle after address
//   in_port     in   [WIDTH-1:0] asynchronous inputs
//   out_port    out  [WIDTH-1:0] output register
//   irq         out  OR(edge_cap & irq_mask)
// ----------------------------------------------------------------------------
module pio_edge_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               EDGE_TYPE       = EDGE_RISING,
    parameter int               DEBOUNCE_CYCLES = 1,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] edge_cap_next;
    logic [WIDTH-1:0] wd;
    logic [31:0]      rd_word;
    logic             wr_en;

    // Register bits above WIDTH do not exist; their write data is discarded.
    logic unused_writedata;
    assign unused_writedata = ^writedata;

    assign wd    = writedata[WIDTH-1:0];
    assign wr_en = chipselect && !write_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_in_chan #(
            .EDGE_TYPE       (EDGE_TYPE),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .in_bit   (in_port[i]),
            .filt     (filt[i]),
            .edge_det (edge_det[i])
        );
    end

    // NOTE: each signal written in always_comb gets a default on entry, so
    // unlisted addresses cannot leave a path that infers a latch.
    always_comb begin
        edge_cap_next = edge_cap;
        if (wr_en && address == ADDR_CAP) begin
            edge_cap_next = edge_cap & ~wd;
        end
        // A new edge is OR-ed in after the clear so it is never lost.
        edge_cap_next = edge_cap_next | edge_det;
    end

    always_comb begin
        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word[WIDTH-1:0] = filt;
            ADDR_OUT:  rd_word[WIDTH-1:0] = out_port;
            ADDR_MASK: rd_word[WIDTH-1:0] = irq_mask;
            ADDR_CAP:  rd_word[WIDTH-1:0] = edge_cap;
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_port <= OUT_RESET;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            edge_cap <= edge_cap_next;
            readdata <= rd_word;
            if (wr_en) begin
                case (address)
                    ADDR_OUT:  out_port <= wd;
                    ADDR_MASK: irq_mask <= wd;
                    ADDR_SET:  out_port <= out_port | wd;
                    ADDR_CLR:  out_port <= out_port & ~wd;
                    default:   ;
                endcase
            end
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule

// File: doc/pio_edge_irq.md
# pio_edge_irq

Parametrised general-purpose I/O slave for the Nios II system bus. It offers a WIDTH-bit input port and a WIDTH-bit output port, with a 2-FF synchroniser on every input bit. Each input bit has a configurable edge detector, a write-1-to-clear capture register and a maskable level interrupt. It replaces single-bit button/switch PIOs in the chenillard system and adds an optional input debounce filter.

## Interface
- WIDTH, 8: number of input and output bits, 1..32.
- EDGE_TYPE, 0: capture condition applied to all bits. 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 1: stability window in clk cycles, ≥1. Used only with PIO_DEBOUNCE_EN.
- OUT_RESET, 0: reset value of out_port, WIDTH bits.

- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word register index.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous inputs.
- out_port  out  WIDTH  output register.
- irq  out  1  level interrupt, equal to OR(edge_cap & irq_mask).

## Operation
- Register map. Bits ≥WIDTH read 0 and ignore writes.
  - 0 DATA: RO, returns the filtered input f. Writes are ignored.
  - 1 OUT: R/W.
  - 2 IRQ_MASK: R/W.
  - 3 EDGE_CAP: read returns captures. Writing 1 clears that bit; writing 0 leaves it unchanged.
  - 4 OUT_SET: write does out |= wd. Reads 0.
  - 5 OUT_CLR: write does out &= ~wd. Reads 0.
  - 6–7: reserved, read 0.
- Per-bit input path:
  - s1 <= in_port; s2 <= s1.
  - f is a registered filtered value; f_prev <= f.
  - edge = f&~f_prev (rising), ~f&f_prev (falling), or f^f_prev (any).
- Capture: edge_cap[i] is set on edge[i]. It stays set until software writes 1 to that bit.
- A W1C write and a new edge on the same bit in the same cycle leave the bit set. The edge wins, so no event is lost.
- The mask is applied only at irq. Captures still accumulate while masked, so unmasking a pending capture raises irq immediately.
- Reset values:
  - s1, s2, f, f_prev, edge_cap, irq_mask, readdata: 0.
  - out_port: OUT_RESET.
  - irq: 0.
  - Debounce counters: 0.
- Reset asserted mid-operation discards all pending captures and counter state in that cycle.
- Bus access:
  - Every cycle: readdata <= mux(address), whether or not chipselect is high.
  - A write occurs when chipselect && !write_n.
  - Writes to a read-only or reserved address are silently dropped.

## Timing
- readdata is valid one cycle after address is presented. There is no wait state.
- Write effects are visible on out_port, irq_mask and edge_cap after the edge on which the write is sampled.
- Input to capture, without debounce: in_port changes before edge 1, then:
  - s1 updates at edge 1.
  - s2 updates at edge 2.
  - f updates at edge 3.
  - edge_cap is set at edge 4, and irq rises after edge 4 if the bit is masked in.
- irq falls in the cycle after the clearing write edge, unless a simultaneous edge re-set the bit.
- Pulses shorter than one clk period may be missed. This is by design.

## Configuration
- PIO_DEBOUNCE_EN defined:
  - Each bit has a counter of $clog2(DEBOUNCE_CYCLES+1) bits.
  - When s2==f, the counter is cleared.
  - When s2!=f, the counter increments.
  - When s2!=f and the counter equals DEBOUNCE_CYCLES-1, f <= s2 and the counter is cleared.
  - Input-to-capture latency is 3+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at s2 never reaches f.
- PIO_DEBOUNCE_EN undefined: f <= s2 every cycle. No counters are instantiated and DEBOUNCE_CYCLES is ignored. Latency is 4 edges, identical to DEBOUNCE_CYCLES=1 with the macro.

## Structure
- Package pio_pkg holds:
  - register address localparams: ADDR_DATA=0, ADDR_OUT=1, ADDR_MASK=2, ADDR_CAP=3, ADDR_SET=4, ADDR_CLR=5;
  - edge-type constants: EDGE_RISING=0, EDGE_FALLING=1, EDGE_ANY=2.
- Sub-module pio_in_chan covers one bit: synchroniser, optional debounce, f/f_prev and edge output. It is generated WIDTH times.
- The top level holds the bus decode, out/mask/capture registers, readdata mux and irq.

## Test plan
- Reset with WIDTH=8, OUT_RESET=8'hA5 → out_port=A5, irq=0, and a read of addr 3 returns 0.
- Writes of OUT=0x0F, then SET=0xF0, then CLR=0x11 → out_port=0x0F, then 0xFF, then 0xEE, and addr 1 reads 0xEE.
- EDGE_TYPE=0, mask=0x04, in_port[2] rises → edge_cap=0x04 and irq=1 at edge 4. A falling in_port[2] adds no capture.
- W1C of 0x04 in the same cycle as a new edge on bit 2 (EDGE_TYPE=2) → bit 2 stays set and irq stays 1. A later W1C clears it and irq goes 0.
- Mask 0, bit 5 toggles → capture set and irq=0. Writing mask=0x20 → irq=1 the next cycle.
- PIO_DEBOUNCE_EN with DEBOUNCE_CYCLES=4:
  - A 3-cycle glitch on bit 0 → no capture and DATA unchanged.
  - A level held for 5 cycles → capture at edge 7.
